// File: rtl/llc_pkg.sv
// Shared types and default geometry for the last-level-cache tag/replacement controller.
package llc_pkg;

    typedef enum logic [1:0] {
        CMD_READ  = 2'd0,
        CMD_WRITE = 2'd1,
        CMD_INV   = 2'd2,
        CMD_CLEAR = 2'd3
    } cmd_e;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_LOOKUP = 2'd2,
        ST_RESP   = 2'd3
    } state_e;

    localparam int DEF_ADDR_W   = 32;
    localparam int DEF_OFFSET_W = 6;
    localparam int DEF_INDEX_W  = 2;
    localparam int DEF_WAYS     = 4;
    localparam int DEF_SETS     = 2 ** DEF_INDEX_W;
    localparam int DEF_TAG_W    = DEF_ADDR_W - DEF_INDEX_W - DEF_OFFSET_W;
    localparam int DEF_PLRU_W   = DEF_WAYS - 1;

endpackage

// File: rtl/plru_tree.sv
// Heap-ordered tree pseudo-LRU: victim lookup and node update for one accessed way.
module plru_tree #(
    parameter int WAYS = 4
) (
    input  logic [WAYS-2:0]         nodes,
    input  logic [$clog2(WAYS)-1:0] access_way,
    output logic [$clog2(WAYS)-1:0] victim,
    output logic [WAYS-2:0]         next_nodes
);

    localparam int WAY_W = $clog2(WAYS);
    localparam int NW    = (WAYS > 2) ? $clog2(WAYS - 1) : 1;

    logic [NW-1:0]    vic_idx;
    logic [NW-1:0]    acc_idx;
    logic [WAY_W-1:0] acc_path;

    // Walk from the root, each node bit choosing the half that holds the victim.
    always_comb begin
        vic_idx = '0;
        victim  = '0;
        for (int l = 0; l < WAY_W; l++) begin
            victim  = (victim << 1) | WAY_W'(nodes[vic_idx]);
            vic_idx = NW'(2 * int'(vic_idx) + 1 + int'(nodes[vic_idx]));
        end
    end

    // Every node on the accessed way's path is turned to point at the other half.
    always_comb begin
        next_nodes = nodes;
        acc_idx    = '0;
        acc_path   = access_way;
        for (int l = 0; l < WAY_W; l++) begin
            next_nodes[acc_idx] = ~acc_path[WAY_W-1];
            acc_idx  = NW'(2 * int'(acc_idx) + 1 + int'(acc_path[WAY_W-1]));
            acc_path = acc_path << 1;
        end
    end

endmodule

// File: rtl/llc_tag_ctrl.sv
// Clocked LLC tag/valid/dirty store with tree PLRU replacement, request handshake and hit/miss counters.
// Handshake: a request transfers on a clock edge where req_valid && req_ready; the response is a one-cycle resp_valid strobe with no backpressure.
module llc_tag_ctrl
    import llc_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int OFFSET_W = 6,
    parameter int INDEX_W  = 2,
    parameter int WAYS     = 4,
    parameter int TAG_W    = ADDR_W - INDEX_W - OFFSET_W,
    parameter int CNT_W    = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [1:0]              req_cmd,
    input  logic [ADDR_W-1:0]       req_addr,
    output logic                    resp_valid,
    output logic                    resp_hit,
    output logic [$clog2(WAYS)-1:0] resp_way,
    output logic                    resp_evict,
    output logic [TAG_W-1:0]        resp_evict_tag,
    output logic                    resp_evict_dirty,
    output logic [CNT_W-1:0]        hit_count,
    output logic [CNT_W-1:0]        miss_count,
    output logic [1:0]              dbg_state
);

    localparam int SETS   = 2 ** INDEX_W;
    localparam int WAY_W  = $clog2(WAYS);
    localparam int PLRU_W = WAYS - 1;

    state_e                       state;
    cmd_e                         cmd_q;
    logic [ADDR_W-OFFSET_W-1:0]   line_q;
    logic [INDEX_W-1:0]           init_cnt;
    logic                         clear_q;

    logic [TAG_W-1:0]             tag_q   [SETS][WAYS];
    logic [WAYS-1:0]              valid_q [SETS];
    logic [WAYS-1:0]              dirty_q [SETS];
    logic [PLRU_W-1:0]            plru_q  [SETS];

    logic [INDEX_W-1:0]           set_idx;
    logic [TAG_W-1:0]             req_tag;
    logic [WAYS-1:0]              vld_set;
    logic [WAYS-1:0]              drt_set;
    logic                         hit;
    logic                         has_inv;
    logic [WAY_W-1:0]             hit_way;
    logic [WAY_W-1:0]             inv_way;
    logic [WAY_W-1:0]             plru_victim;
    logic [WAY_W-1:0]             sel_way;
    logic [PLRU_W-1:0]            plru_next;
    logic                         victim_valid;
    logic                         is_rw;
    logic                         unused_offset;

    assign unused_offset = ^req_addr[OFFSET_W-1:0];
    assign dbg_state     = state;
    assign set_idx       = line_q[INDEX_W-1:0];
    assign req_tag       = line_q[ADDR_W-OFFSET_W-1:INDEX_W];
    assign is_rw         = (cmd_q == CMD_READ) || (cmd_q == CMD_WRITE);

    // Parallel tag compare; descending scan leaves the lowest matching / invalid way.
    always_comb begin
        vld_set = valid_q[set_idx];
        drt_set = dirty_q[set_idx];
        hit     = 1'b0;
        hit_way = '0;
        has_inv = 1'b0;
        inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (vld_set[w] && (tag_q[set_idx][w] == req_tag)) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!vld_set[w]) begin
                has_inv = 1'b1;
                inv_way = WAY_W'(w);
            end
        end
        sel_way      = hit ? hit_way : (has_inv ? inv_way : plru_victim);
        victim_valid = !hit && vld_set[sel_way];
    end

    plru_tree #(.WAYS(WAYS)) u_plru (
        .nodes      (plru_q[set_idx]),
        .access_way (sel_way),
        .victim     (plru_victim),
        .next_nodes (plru_next)
    );

    // Tags carry no reset; valid, dirty and PLRU are swept clear by INIT before any lookup.
    always_ff @(posedge clk) begin
        if (state == ST_INIT) begin
            valid_q[init_cnt] <= '0;
            dirty_q[init_cnt] <= '0;
            plru_q[init_cnt]  <= '0;
        end else if (state == ST_LOOKUP) begin
            if (is_rw) begin
                plru_q[set_idx]           <= plru_next;
                valid_q[set_idx][sel_way] <= 1'b1;
                tag_q[set_idx][sel_way]   <= req_tag;
                dirty_q[set_idx][sel_way] <= (cmd_q == CMD_WRITE) || (hit && drt_set[sel_way]);
            end else if (cmd_q == CMD_INV && hit) begin
                valid_q[set_idx][hit_way] <= 1'b0;
                dirty_q[set_idx][hit_way] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= ST_INIT;
            cmd_q            <= CMD_READ;
            line_q           <= '0;
            init_cnt         <= '0;
            clear_q          <= 1'b0;
            req_ready        <= 1'b0;
            resp_valid       <= 1'b0;
            resp_hit         <= 1'b0;
            resp_way         <= '0;
            resp_evict       <= 1'b0;
            resp_evict_tag   <= '0;
            resp_evict_dirty <= 1'b0;
            hit_count        <= '0;
            miss_count       <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    init_cnt <= init_cnt + INDEX_W'(1);
                    if (init_cnt == INDEX_W'(SETS - 1)) begin
                        state     <= ST_IDLE;
                        req_ready <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (req_valid) begin
                        cmd_q     <= cmd_e'(req_cmd);
                        line_q    <= req_addr[ADDR_W-1:OFFSET_W];
                        req_ready <= 1'b0;
                        state     <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    resp_valid       <= 1'b1;
                    state            <= ST_RESP;
                    resp_hit         <= 1'b0;
                    resp_way         <= '0;
                    resp_evict       <= 1'b0;
                    resp_evict_tag   <= '0;
                    resp_evict_dirty <= 1'b0;
                    if (is_rw) begin
                        resp_hit         <= hit;
                        resp_way         <= sel_way;
                        resp_evict       <= victim_valid;
                        resp_evict_tag   <= victim_valid ? tag_q[set_idx][sel_way] : '0;
                        resp_evict_dirty <= victim_valid && drt_set[sel_way];
                        if (hit) begin
                            if (hit_count != '1) hit_count <= hit_count + CNT_W'(1);
                        end else begin
                            if (miss_count != '1) miss_count <= miss_count + CNT_W'(1);
                        end
                    end else if (cmd_q == CMD_INV) begin
                        if (hit) begin
                            resp_hit         <= 1'b1;
                            resp_way         <= hit_way;
                            resp_evict       <= 1'b1;
                            resp_evict_tag   <= req_tag;
                            resp_evict_dirty <= drt_set[hit_way];
                        end
                    end else begin
                        clear_q <= 1'b1;
                    end
                end
                ST_RESP: begin
                    resp_valid <= 1'b0;
                    if (clear_q) begin
                        clear_q  <= 1'b0;
                        init_cnt <= '0;
                        state    <= ST_INIT;
                    end else begin
                        req_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_llc_tag_ctrl.sv
// Bench for llc_tag_ctrl: directed scenarios plus randomized traffic against a behavioural cache model.
module tb_llc_tag_ctrl;

    localparam int ADDR_W   = 32;
    localparam int OFFSET_W = 6;
    localparam int INDEX_W  = 2;
    localparam int WAYS     = 4;
    localparam int CNT_W    = 6;
    localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
    localparam int SETS     = 4;
    localparam int WAY_W    = 2;
    localparam int RW       = 1 + WAY_W + 1 + TAG_W + 1;
    localparam int CNT_MAX  = 63;
    localparam logic [1:0] C_RD = 2'd0, C_WR = 2'd1, C_INV = 2'd2, C_CLR = 2'd3;

    logic                clk;
    logic                rst_n;
    logic                req_valid;
    logic                req_ready;
    logic [1:0]          req_cmd;
    logic [ADDR_W-1:0]   req_addr;
    logic                resp_valid;
    logic                resp_hit;
    logic [WAY_W-1:0]    resp_way;
    logic                resp_evict;
    logic [TAG_W-1:0]    resp_evict_tag;
    logic                resp_evict_dirty;
    logic [CNT_W-1:0]    hit_count;
    logic [CNT_W-1:0]    miss_count;
    logic [1:0]          dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [RW-1:0]    exp_q[$];
    logic             r_hit, r_evict, r_dirty;
    logic [WAY_W-1:0] r_way;
    logic [TAG_W-1:0] r_tag;

    logic [TAG_W-1:0] m_tag  [SETS][WAYS];
    bit               m_vld  [SETS][WAYS];
    bit               m_drt  [SETS][WAYS];
    bit               m_plru [SETS][WAYS-1];
    int               m_hits, m_miss;

    llc_tag_ctrl #(
        .ADDR_W(ADDR_W), .OFFSET_W(OFFSET_W), .INDEX_W(INDEX_W), .WAYS(WAYS), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_cmd(req_cmd), .req_addr(req_addr), .resp_valid(resp_valid), .resp_hit(resp_hit),
        .resp_way(resp_way), .resp_evict(resp_evict), .resp_evict_tag(resp_evict_tag),
        .resp_evict_dirty(resp_evict_dirty), .hit_count(hit_count), .miss_count(miss_count),
        .dbg_state(dbg_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    task automatic model_clear();
        for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
                m_vld[s][w] = 1'b0;
                m_drt[s][w] = 1'b0;
                m_tag[s][w] = '0;
            end
            for (int n = 0; n < WAYS - 1; n++) m_plru[s][n] = 1'b0;
        end
    endtask

    function automatic int model_victim(int s);
        int node = 0;
        int lo   = 0;
        int span = WAYS;
        while (span > 1) begin
            span = span / 2;
            if (m_plru[s][node]) begin
                lo   = lo + span;
                node = 2 * node + 2;
            end else begin
                node = 2 * node + 1;
            end
        end
        return lo;
    endfunction

    task automatic model_touch(input int s, input int w);
        int node = 0;
        int lo   = 0;
        int span = WAYS;
        bit upper;
        while (span > 1) begin
            span  = span / 2;
            upper = (w >= lo + span);
            m_plru[s][node] = !upper;
            if (upper) begin
                lo   = lo + span;
                node = 2 * node + 2;
            end else begin
                node = 2 * node + 1;
            end
        end
    endtask

    task automatic model_req(input logic [1:0] cmd, input logic [ADDR_W-1:0] addr,
                             output logic [RW-1:0] exp);
        int s, w;
        logic [TAG_W-1:0] t;
        logic ev, evd;
        logic [TAG_W-1:0] evt;
        s = int'(addr[OFFSET_W +: INDEX_W]);
        t = addr[ADDR_W-1 -: TAG_W];
        w = -1;
        for (int i = 0; i < WAYS; i++) if (m_vld[s][i] && m_tag[s][i] == t) w = i;
        exp = '0;
        case (cmd)
            C_RD, C_WR: begin
                if (w >= 0) begin
                    exp = {1'b1, WAY_W'(w), 1'b0, TAG_W'(0), 1'b0};
                    if (cmd == C_WR) m_drt[s][w] = 1'b1;
                    model_touch(s, w);
                    if (m_hits < CNT_MAX) m_hits++;
                end else begin
                    for (int i = WAYS - 1; i >= 0; i--) if (!m_vld[s][i]) w = i;
                    if (w < 0) w = model_victim(s);
                    ev  = m_vld[s][w];
                    evt = ev ? m_tag[s][w] : TAG_W'(0);
                    evd = ev && m_drt[s][w];
                    exp = {1'b0, WAY_W'(w), ev, evt, evd};
                    m_tag[s][w] = t;
                    m_vld[s][w] = 1'b1;
                    m_drt[s][w] = (cmd == C_WR);
                    model_touch(s, w);
                    if (m_miss < CNT_MAX) m_miss++;
                end
            end
            C_INV: begin
                if (w >= 0) begin
                    evd = m_drt[s][w];
                    exp = {1'b1, WAY_W'(w), 1'b1, t, evd};
                    m_vld[s][w] = 1'b0;
                    m_drt[s][w] = 1'b0;
                end
            end
            default: model_clear();
        endcase
    endtask

    function automatic logic [ADDR_W-1:0] mk_addr(input logic [TAG_W-1:0] tag, input int s);
        logic [OFFSET_W-1:0] off;
        off = OFFSET_W'($urandom_range(0, 63));
        return {tag, INDEX_W'(s), off};
    endfunction

    // ---------------- driver: one request, full protocol check ----------------
    task automatic issue(input logic [1:0] cmd, input logic [ADDR_W-1:0] addr);
        logic [RW-1:0] exp, act, e;
        int waited;
        model_req(cmd, addr, exp);
        exp_q.push_back(exp);
        @(negedge clk);
        req_valid = 1'b1;
        req_cmd   = cmd;
        req_addr  = addr;
        waited    = 0;
        while (!req_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (!req_ready) begin
            n_fail++;
            $display("FAIL ready_timeout: req_ready=%0b after %0d cycles, required 1", req_ready, waited);
            req_valid = 1'b0;
            e = exp_q.pop_front();
            return;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_cmd   = 2'($urandom_range(0, 3));
        req_addr  = $urandom;
        n_checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL accept_cycle: resp_valid=%0b req_ready=%0b, required 0 0", resp_valid, req_ready);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (resp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL resp_latency: resp_valid=%0b, required 1", resp_valid);
        end
        act = {resp_hit, resp_way, resp_evict, resp_evict_tag, resp_evict_dirty};
        {r_hit, r_way, r_evict, r_tag, r_dirty} = act;
        e = exp_q.pop_front();
        n_checks++;
        if (act !== e) begin
            n_fail++;
            $display("FAIL resp_fields cmd=%0d addr=%h: got hit=%0b way=%0d ev=%0b tag=%h d=%0b, required hit=%0b way=%0d ev=%0b tag=%h d=%0b",
                     cmd, addr, act[RW-1], act[RW-2 -: WAY_W], act[TAG_W+1], act[TAG_W:1], act[0],
                     e[RW-1], e[RW-2 -: WAY_W], e[TAG_W+1], e[TAG_W:1], e[0]);
        end
        n_checks++;
        if (hit_count !== CNT_W'(m_hits) || miss_count !== CNT_W'(m_miss)) begin
            n_fail++;
            $display("FAIL counters: hit=%0d miss=%0d, required %0d %0d", hit_count, miss_count, m_hits, m_miss);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (resp_valid !== 1'b0 || {resp_hit, resp_way, resp_evict, resp_evict_tag, resp_evict_dirty} !== act) begin
            n_fail++;
            $display("FAIL resp_pulse_hold: resp_valid=%0b, fields changed=%0b, required 0 0", resp_valid,
                     {resp_hit, resp_way, resp_evict, resp_evict_tag, resp_evict_dirty} !== act);
        end
        if (cmd != C_CLR) begin
            n_checks++;
            if (req_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL ready_return: req_ready=%0b, required 1", req_ready);
            end
        end
    endtask

    task automatic count_init(input string name);
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!req_ready && n < 20);
        n_checks++;
        if (n !== SETS) begin
            n_fail++;
            $display("FAIL %s: req_ready rose after %0d cycles, required %0d", name, n, SETS);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        req_valid = 1'b0;
        req_cmd   = '0;
        req_addr  = '0;
        rst_n     = 1'b1;
        #1 rst_n  = 1'b0;
        m_hits = 0;
        m_miss = 0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({req_ready, resp_valid, resp_hit, resp_way, resp_evict, resp_evict_tag, resp_evict_dirty} !== '0
            || hit_count !== '0 || miss_count !== '0) begin
            n_fail++;
            $display("FAIL reset_values: ready=%0b valid=%0b hit=%0b way=%0d ev=%0b tag=%h d=%0b hc=%0d mc=%0d, required all 0",
                     req_ready, resp_valid, resp_hit, resp_way, resp_evict, resp_evict_tag, resp_evict_dirty,
                     hit_count, miss_count);
        end
        @(negedge clk);
        req_valid = 1'b1;
        rst_n     = 1'b1;
        count_init("reset_init_len");
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic test_cold_fill();
        for (int i = 0; i < 4; i++) begin
            issue(C_RD, mk_addr(TAG_W'(24'hA0000A + i), 0));
            n_checks++;
            if (r_hit !== 1'b0 || r_way !== WAY_W'(i) || r_evict !== 1'b0) begin
                n_fail++;
                $display("FAIL cold_fill_%0d: hit=%0b way=%0d ev=%0b, required 0 %0d 0", i, r_hit, r_way, r_evict, i);
            end
        end
        n_checks++;
        if (miss_count !== CNT_W'(4)) begin
            n_fail++;
            $display("FAIL cold_fill_misses: miss_count=%0d, required 4", miss_count);
        end
    endtask

    task automatic test_plru_victim();
        issue(C_RD, mk_addr(TAG_W'(24'hA0000A), 0));
        n_checks++;
        if (r_hit !== 1'b1 || r_way !== 2'd0) begin
            n_fail++;
            $display("FAIL plru_hit_a: hit=%0b way=%0d, required 1 0", r_hit, r_way);
        end
        issue(C_RD, mk_addr(TAG_W'(24'hA0000E), 0));
        n_checks++;
        if (r_way !== 2'd2 || r_evict !== 1'b1 || r_tag !== TAG_W'(24'hA0000C) || r_dirty !== 1'b0
            || hit_count !== CNT_W'(1)) begin
            n_fail++;
            $display("FAIL plru_victim: way=%0d ev=%0b tag=%h d=%0b hc=%0d, required 2 1 a0000c 0 1",
                     r_way, r_evict, r_tag, r_dirty, hit_count);
        end
    endtask

    task automatic test_dirty_writeback();
        issue(C_WR, mk_addr(TAG_W'(24'hA0000B), 0));
        n_checks++;
        if (r_hit !== 1'b1 || r_way !== 2'd1) begin
            n_fail++;
            $display("FAIL write_hit_b: hit=%0b way=%0d, required 1 1", r_hit, r_way);
        end
        for (int i = 0; i < 4; i++) issue(C_RD, mk_addr(TAG_W'(24'hB00000 + i), 0));
        n_checks++;
        if (r_way !== 2'd1 || r_evict !== 1'b1 || r_tag !== TAG_W'(24'hA0000B) || r_dirty !== 1'b1) begin
            n_fail++;
            $display("FAIL dirty_writeback: way=%0d ev=%0b tag=%h d=%0b, required 1 1 a0000b 1",
                     r_way, r_evict, r_tag, r_dirty);
        end
    endtask

    task automatic test_invalidate();
        for (int i = 0; i < 4; i++) issue(C_RD, mk_addr(TAG_W'(24'hA0000A + i), 1));
        issue(C_INV, mk_addr(TAG_W'(24'hA0000D), 1));
        n_checks++;
        if (r_hit !== 1'b1 || r_way !== 2'd3 || r_evict !== 1'b1 || r_tag !== TAG_W'(24'hA0000D)) begin
            n_fail++;
            $display("FAIL invalidate_hit: hit=%0b way=%0d ev=%0b tag=%h, required 1 3 1 a0000d",
                     r_hit, r_way, r_evict, r_tag);
        end
        issue(C_INV, mk_addr(TAG_W'(24'hA0000D), 1));
        n_checks++;
        if (r_hit !== 1'b0 || r_evict !== 1'b0) begin
            n_fail++;
            $display("FAIL invalidate_miss: hit=%0b ev=%0b, required 0 0", r_hit, r_evict);
        end
    endtask

    task automatic test_clear();
        logic [CNT_W-1:0] hc, mc;
        hc = hit_count;
        mc = miss_count;
        issue(C_CLR, mk_addr(TAG_W'($urandom), 2));
        count_init("clear_init_len");
        n_checks++;
        if (hit_count !== hc || miss_count !== mc || hc === '0) begin
            n_fail++;
            $display("FAIL clear_keeps_counters: hit=%0d miss=%0d, required %0d %0d (nonzero)", hit_count, miss_count, hc, mc);
        end
        issue(C_RD, mk_addr(TAG_W'(24'hA0000A), 0));
        n_checks++;
        if (r_hit !== 1'b0 || r_way !== 2'd0 || r_evict !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_refill: hit=%0b way=%0d ev=%0b, required 0 0 0", r_hit, r_way, r_evict);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) issue(C_WR, mk_addr(TAG_W'(24'hC00000 + (i % 3)), 3));
    endtask

    task automatic test_random();
        int r;
        logic [1:0] cmd;
        for (int i = 0; i < 300; i++) begin
            r   = $urandom_range(0, 99);
            cmd = (r < 45) ? C_RD : (r < 80) ? C_WR : (r < 97) ? C_INV : C_CLR;
            issue(cmd, mk_addr(TAG_W'(24'h00A000 + $urandom_range(0, 5)), $urandom_range(0, SETS - 1)));
        end
        n_checks++;
        if (hit_count !== CNT_W'(CNT_MAX) || miss_count !== CNT_W'(CNT_MAX)) begin
            n_fail++;
            $display("FAIL counter_saturation: hit=%0d miss=%0d, required %0d %0d", hit_count, miss_count, CNT_MAX, CNT_MAX);
        end
    endtask

    task automatic test_reset_midop();
        int seen = 0;
        @(negedge clk);
        req_valid = 1'b1;
        req_cmd   = C_RD;
        req_addr  = mk_addr(TAG_W'(24'hD00000), 0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst_n     = 1'b0;
        m_hits = 0;
        m_miss = 0;
        model_clear();
        repeat (3) begin
            @(posedge clk);
            #1;
            if (resp_valid !== 1'b0) seen++;
        end
        n_checks++;
        if (seen != 0 || hit_count !== '0 || miss_count !== '0 || req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_abort: resp pulses=%0d hc=%0d mc=%0d ready=%0b, required 0 0 0 0",
                     seen, hit_count, miss_count, req_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        count_init("midop_init_len");
        issue(C_RD, mk_addr(TAG_W'(24'h00A000), 0));
    endtask

    initial begin
        test_reset();
        test_cold_fill();
        test_plru_victim();
        test_dirty_writeback();
        test_invalidate();
        test_clear();
        test_back_to_back();
        test_random();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1, "timeout");
    end

endmodule
